// File: rtl/read_bpm_link_gen_pkg.sv
// Shared definitions for the BPM-link receiver: status codes, default magic
// and the parser state encoding.
package bpm_link_pkg;

  localparam logic [1:0] ST_SUCCESS    = 2'd0;
  localparam logic [1:0] ST_BAD_HEADER = 2'd1;
  localparam logic [1:0] ST_BAD_SIZE   = 2'd2;
  localparam logic [1:0] ST_BAD_PACKET = 2'd3;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA5BE;

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/read_bpm_link_gen_sat_counter.sv
// Saturating event counter; a clear on the same cycle as an increment wins.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/read_bpm_link_gen.sv
// BPM-link packet receiver: parses header + NWORDS payload beats from the
// Aurora AXI-Stream, reports each outcome and keeps per-outcome statistics.
module read_bpm_link_gen
  import bpm_link_pkg::*;
#(
  parameter int          NWORDS    = 3,
  parameter logic [15:0] MAGIC     = DEFAULT_MAGIC,
  parameter int          TIMEOUT   = 1023,
  parameter int          CNT_WIDTH = 16,
  parameter string       dbg       = "false"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              TDATA,
  input  logic                     TVALID,
  input  logic                     TLAST,
  input  logic                     CRC_VALID,
  input  logic                     CRC_PASS,
  input  logic                     inhibit,
  input  logic                     clearCounters,
  output logic                     outputStrobe,
  output logic [16+32*NWORDS-1:0]  outputData,
  output logic                     statusStrobe,
  output logic [1:0]               statusCode,
  output logic [CNT_WIDTH-1:0]     goodCount,
  output logic [CNT_WIDTH-1:0]     badHeaderCount,
  output logic [CNT_WIDTH-1:0]     badSizeCount,
  output logic [CNT_WIDTH-1:0]     badPacketCount
);

  localparam int OW  = 16 + 32 * NWORDS;
  localparam int IW  = $clog2(NWORDS + 1);
  localparam int IDW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NWORDS);
  localparam logic [IDW-1:0] IDLE_LAST = IDW'(TIMEOUT - 1);

  (* mark_debug = dbg *) state_e state_q;
  state_e state_d;
  logic [IW-1:0]  index_q, index_d;
  logic [IDW-1:0] idle_q, idle_d;
  logic [OW-1:0]  data_q, data_d;
  (* mark_debug = dbg *) logic statusStrobe_q;
  (* mark_debug = dbg *) logic [1:0] statusCode_q;
  logic outputStrobe_q;

  logic       report;
  logic [1:0] code;
  logic       good;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    idle_d  = idle_q;
    data_d  = data_q;
    report  = 1'b0;
    code    = ST_SUCCESS;
    good    = 1'b0;
    case (state_q)
      S_HEADER: begin
        idle_d = '0;
        if (TVALID) begin
          if (TLAST) begin
            report = 1'b1;
            code   = ST_BAD_SIZE;
          end else if (TDATA[31:16] != MAGIC) begin
            report  = 1'b1;
            code    = ST_BAD_HEADER;
            state_d = S_DRAIN;
          end else begin
            data_d[OW-1 -: 16] = TDATA[15:0];
            index_d = IW'(1);
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (TVALID) begin
          idle_d = '0;
          if (index_q == IDX_LAST) begin
            // The flag bit is kept in bit 31 but bit 30 is forced clear.
            data_d[31:0] = {TDATA[31], 1'b0, TDATA[29:0]};
            report  = 1'b1;
            index_d = '0;
            state_d = S_HEADER;
            if (!TLAST) begin
              code    = ST_BAD_SIZE;
              state_d = S_DRAIN;
            end else if (CRC_VALID && CRC_PASS && !TDATA[31]) begin
              code = ST_SUCCESS;
              good = 1'b1;
            end else begin
              code = ST_BAD_PACKET;
            end
          end else if (TLAST) begin
            report  = 1'b1;
            code    = ST_BAD_SIZE;
            index_d = '0;
            state_d = S_HEADER;
          end else begin
            data_d[32*(NWORDS - int'(index_q)) +: 32] = TDATA;
            index_d = index_q + IW'(1);
          end
        end else if (idle_q == IDLE_LAST) begin
          report  = 1'b1;
          code    = ST_BAD_SIZE;
          idle_d  = '0;
          index_d = '0;
          state_d = S_HEADER;
        end else begin
          idle_d = idle_q + IDW'(1);
        end
      end
      S_DRAIN: begin
        if (TVALID) begin
          idle_d = '0;
          if (TLAST) begin
            state_d = S_HEADER;
          end
        end else if (idle_q == IDLE_LAST) begin
          idle_d  = '0;
          state_d = S_HEADER;
        end else begin
          idle_d = idle_q + IDW'(1);
        end
      end
      default: begin
        state_d = S_HEADER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_HEADER;
      index_q        <= '0;
      idle_q         <= '0;
      data_q         <= '0;
      statusStrobe_q <= 1'b0;
      statusCode_q   <= ST_SUCCESS;
      outputStrobe_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      idle_q         <= idle_d;
      data_q         <= data_d;
      statusStrobe_q <= report;
      statusCode_q   <= report ? code : statusCode_q;
      outputStrobe_q <= good && !inhibit;
    end
  end

  // Inhibited good packets still count as SUCCESS.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_goodCnt (
    .clk(clk), .reset(reset), .inc(report && (code == ST_SUCCESS)),
    .clr(clearCounters), .count(goodCount)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_badHeaderCnt (
    .clk(clk), .reset(reset), .inc(report && (code == ST_BAD_HEADER)),
    .clr(clearCounters), .count(badHeaderCount)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_badSizeCnt (
    .clk(clk), .reset(reset), .inc(report && (code == ST_BAD_SIZE)),
    .clr(clearCounters), .count(badSizeCount)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_badPacketCnt (
    .clk(clk), .reset(reset), .inc(report && (code == ST_BAD_PACKET)),
    .clr(clearCounters), .count(badPacketCount)
  );

  assign outputStrobe = outputStrobe_q;
  assign outputData   = data_q;
  assign statusStrobe = statusStrobe_q;
  assign statusCode   = statusCode_q;

endmodule

// File: tb/tb_read_bpm_link_gen.sv
// Self-checking bench for read_bpm_link_gen: hand-written vector table, corner
// sequences and random packets checked against a packet-level reference model.
module tb_read_bpm_link_gen;

  localparam int NW   = 3;
  localparam int OW   = 16 + 32 * NW;
  localparam int TMO  = 8;
  localparam int CW   = 4;
  localparam logic [15:0] MAG = 16'hA5BE;
  localparam int SATV = (1 << CW) - 1;

  logic           clk;
  logic           reset;
  logic [31:0]    TDATA;
  logic           TVALID, TLAST, CRC_VALID, CRC_PASS, inhibit, clearCounters;
  logic           outputStrobe, statusStrobe;
  logic [OW-1:0]  outputData;
  logic [1:0]     statusCode;
  logic [CW-1:0]  goodCount, badHeaderCount, badSizeCount, badPacketCount;

  read_bpm_link_gen #(
    .NWORDS(NW), .MAGIC(MAG), .TIMEOUT(TMO), .CNT_WIDTH(CW), .dbg("false")
  ) dut (
    .clk(clk), .reset(reset), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST),
    .CRC_VALID(CRC_VALID), .CRC_PASS(CRC_PASS), .inhibit(inhibit),
    .clearCounters(clearCounters), .outputStrobe(outputStrobe),
    .outputData(outputData), .statusStrobe(statusStrobe),
    .statusCode(statusCode), .goodCount(goodCount),
    .badHeaderCount(badHeaderCount), .badSizeCount(badSizeCount),
    .badPacketCount(badPacketCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string         name;
    int            nBeats;
    logic [31:0]   beats [6];
    logic          crcv;
    logic          crcp;
    logic          inh;
    logic [1:0]    code;
    logic          strobe;
    logic [OW-1:0] data;
  } vec_t;

  vec_t          vecs[$];
  logic [31:0]   pktBeats[$];
  logic [1:0]    obsCode[$];
  logic [OW-1:0] obsData[$];
  logic [1:0]    expCode[$];
  logic [OW-1:0] expData[$];
  int            modelCnt [4];
  int            checks = 0;
  int            failures = 0;

  // Reports are collected away from the active edge and compared in batches.
  always @(negedge clk) begin
    if (statusStrobe === 1'b1) obsCode.push_back(statusCode);
    if (outputStrobe === 1'b1) obsData.push_back(outputData);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    TVALID = 1'b0;
    TLAST  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit withLast, input logic crcv, input logic crcp,
                               input logic inh, input bit clrLast, input int gapMax);
    inhibit = inh;
    for (int i = 0; i < pktBeats.size(); i++) begin
      TDATA     = pktBeats[i];
      TVALID    = 1'b1;
      TLAST     = withLast && (i == pktBeats.size() - 1);
      CRC_VALID = crcv;
      CRC_PASS  = crcp;
      clearCounters = clrLast && (i == pktBeats.size() - 1);
      @(negedge clk);
      clearCounters = 1'b0;
      if (gapMax > 0 && i != pktBeats.size() - 1) idle($urandom_range(0, gapMax));
    end
    TVALID  = 1'b0;
    TLAST   = 1'b0;
    inhibit = 1'b0;
  endtask

  task automatic noteReport(input logic [1:0] code, input logic [OW-1:0] data, input bit strobe);
    expCode.push_back(code);
    if (strobe) expData.push_back(data);
    if (modelCnt[code] < SATV) modelCnt[code]++;
  endtask

  // Packet-level reference: classify a whole TLAST-terminated packet.
  task automatic modelPacket(input logic crcv, input logic crcp, input logic inh);
    logic [OW-1:0] d;
    logic [31:0]   fin;
    int            n;
    n = pktBeats.size();
    if (n == 1) begin
      noteReport(2'd2, '0, 1'b0);
    end else if (pktBeats[0][31:16] != MAG) begin
      noteReport(2'd1, '0, 1'b0);
    end else if (n - 1 != NW) begin
      noteReport(2'd2, '0, 1'b0);
    end else begin
      fin = pktBeats[NW];
      d = {pktBeats[0][15:0], pktBeats[1], pktBeats[2], fin[31], 1'b0, fin[29:0]};
      if (crcv && crcp && !fin[31]) noteReport(2'd0, d, !inh);
      else noteReport(2'd3, '0, 1'b0);
    end
  endtask

  task automatic checkReports(input string name);
    checkOutput({name, "_nreports"}, 128'(obsCode.size()), 128'(expCode.size()));
    for (int i = 0; i < obsCode.size() && i < expCode.size(); i++)
      checkOutput({name, "_code"}, 128'(obsCode[i]), 128'(expCode[i]));
    checkOutput({name, "_nstrobes"}, 128'(obsData.size()), 128'(expData.size()));
    for (int i = 0; i < obsData.size() && i < expData.size(); i++)
      checkOutput({name, "_data"}, 128'(obsData[i]), 128'(expData[i]));
    obsCode.delete(); obsData.delete(); expCode.delete(); expData.delete();
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_good"}, 128'(goodCount), 128'(modelCnt[0]));
    checkOutput({name, "_badHeader"}, 128'(badHeaderCount), 128'(modelCnt[1]));
    checkOutput({name, "_badSize"}, 128'(badSizeCount), 128'(modelCnt[2]));
    checkOutput({name, "_badPacket"}, 128'(badPacketCount), 128'(modelCnt[3]));
  endtask

  task automatic addVec(input string name, input int n, input logic [31:0] b0, b1, b2, b3, b4,
                        input logic crcv, crcp, inh, input logic [1:0] code,
                        input logic strobe, input logic [OW-1:0] data);
    vec_t v;
    v.name = name; v.nBeats = n;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3; v.beats[4] = b4;
    v.beats[5] = 32'h0;
    v.crcv = crcv; v.crcp = crcp; v.inh = inh;
    v.code = code; v.strobe = strobe; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    TVALID = 1'b0; TLAST = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) modelCnt[i] = 0;
    obsCode.delete(); obsData.delete();
  endtask

  localparam logic [OW-1:0] GOOD7 = 112'h0007_00000010_FFFFFFF0_00000001;

  initial begin
    TDATA = '0; TVALID = 0; TLAST = 0; CRC_VALID = 0; CRC_PASS = 0;
    inhibit = 0; clearCounters = 0; reset = 1;
    doReset();
    checkOutput("reset_outputData", 128'(outputData), 128'(0));
    checkOutput("reset_statusCode", 128'(statusCode), 128'(0));
    checkOutput("reset_statusStrobe", 128'(statusStrobe), 128'(0));
    checkOutput("reset_outputStrobe", 128'(outputStrobe), 128'(0));
    checkCounters("reset");

    addVec("good", 4, 32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001, 0, 1, 1, 0, 2'd0, 1, GOOD7);
    addVec("badMagic", 4, 32'h12340000, 32'h1, 32'h2, 32'h3, 0, 1, 1, 0, 2'd1, 0, '0);
    addVec("goodAgain", 4, 32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001, 0, 1, 1, 0, 2'd0, 1, GOOD7);
    addVec("short", 3, 32'hA5BE0001, 32'h11111111, 32'h22222222, 0, 0, 1, 1, 0, 2'd2, 0, '0);
    addVec("long", 5, 32'hA5BE0002, 32'hA, 32'hB, 32'hC, 32'hD, 1, 1, 0, 2'd2, 0, '0);
    addVec("flagSet", 4, 32'hA5BE0003, 32'h1, 32'h2, 32'h80000000, 0, 1, 1, 0, 2'd3, 0, '0);
    addVec("crcFail", 4, 32'hA5BE0004, 32'h1, 32'h2, 32'h3, 0, 1, 0, 0, 2'd3, 0, '0);
    addVec("crcInvalid", 4, 32'hA5BE0004, 32'h1, 32'h2, 32'h3, 0, 0, 1, 0, 2'd3, 0, '0);
    addVec("inhibited", 4, 32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001, 0, 1, 1, 1, 2'd0, 0, '0);
    addVec("headerLast", 1, 32'hA5BE0005, 0, 0, 0, 0, 1, 1, 0, 2'd2, 0, '0);

    foreach (vecs[k]) begin
      pktBeats.delete();
      for (int i = 0; i < vecs[k].nBeats; i++) pktBeats.push_back(vecs[k].beats[i]);
      noteReport(vecs[k].code, vecs[k].data, vecs[k].strobe);
      applyStimulus(1, vecs[k].crcv, vecs[k].crcp, vecs[k].inh, 0, 0);
      idle(2);
      checkReports(vecs[k].name);
    end
    checkCounters("table");
    checkOutput("table_goodCount_const", 128'(goodCount), 128'(3));

    // Back-to-back packets with no dead cycle.
    pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    pktBeats = '{32'hA5BE0009, 32'h1, 32'h2, 32'h3};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    idle(2);
    checkReports("backToBack");

    // Stall of exactly TIMEOUT cycles mid-payload.
    pktBeats = '{32'hA5BE0008, 32'h1, 32'h2};
    applyStimulus(0, 1, 1, 0, 0, 0);
    idle(TMO);
    noteReport(2'd2, '0, 0);
    idle(2);
    checkReports("stallTimeout");
    pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    idle(2);
    checkReports("afterTimeout");

    // One cycle short of the timeout must not abort the packet.
    pktBeats = '{32'hA5BE000A, 32'h1, 32'h2};
    applyStimulus(0, 1, 1, 0, 0, 0);
    idle(TMO - 1);
    pktBeats = '{32'h00000005};
    applyStimulus(1, 1, 1, 0, 0, 0);
    noteReport(2'd0, 112'h000A_00000001_00000002_00000005, 1);
    idle(2);
    checkReports("stallBelowTimeout");

    // DRAIN times out silently and the next header is parsed.
    pktBeats = '{32'h12340000, 32'h1};
    noteReport(2'd1, '0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    idle(TMO);
    pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    idle(2);
    checkReports("drainTimeout");
    checkCounters("corners");

    // Random packets against the packet-level model.
    for (int p = 0; p < 60; p++) begin
      int len;
      logic crcv, crcp, inh;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NW + 3)) : NW + 1;
      pktBeats.delete();
      pktBeats.push_back({($urandom_range(0, 4) == 0) ? 16'h1234 : MAG, 16'($urandom)});
      for (int i = 1; i < len; i++) pktBeats.push_back($urandom);
      if (len > 1) pktBeats[len-1][31] = ($urandom_range(0, 3) == 0);
      crcv = ($urandom_range(0, 7) != 0);
      crcp = ($urandom_range(0, 7) != 0);
      inh  = ($urandom_range(0, 5) == 0);
      modelPacket(crcv, crcp, inh);
      applyStimulus(1, crcv, crcp, inh, 0, TMO - 2);
      idle(2);
      checkReports("random");
      if (p % 10 == 9) checkCounters("random");
    end

    // Saturation of the statistics counters.
    clearCounters = 1'b1;
    @(negedge clk);
    clearCounters = 1'b0;
    for (int i = 0; i < 4; i++) modelCnt[i] = 0;
    for (int p = 0; p < (1 << CW) + 3; p++) begin
      pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
      modelPacket(1, 1, 0);
      applyStimulus(1, 1, 1, 0, 0, 0);
    end
    idle(2);
    checkReports("saturate");
    checkOutput("saturate_goodCount", 128'(goodCount), 128'(SATV));
    checkCounters("saturate");

    // Clear coinciding with a report: counter cleared, strobe still issued.
    pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) modelCnt[i] = 0;
    idle(2);
    checkReports("clearCoincident");
    checkOutput("clearCoincident_goodCount", 128'(goodCount), 128'(0));

    // Reset mid-packet discards the partial packet without a report.
    pktBeats = '{32'hA5BE0003, 32'h1, 32'h2, 32'h80000000};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    idle(2);
    checkReports("preReset");
    pktBeats = '{32'hA5BE0007, 32'h10};
    applyStimulus(0, 1, 1, 0, 0, 0);
    doReset();
    idle(2);
    checkReports("midReset");
    checkOutput("midReset_outputData", 128'(outputData), 128'(0));
    checkOutput("midReset_statusCode", 128'(statusCode), 128'(0));
    checkCounters("midReset");
    pktBeats = '{32'hA5BE0007, 32'h10, 32'hFFFFFFF0, 32'h40000001};
    modelPacket(1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    idle(2);
    checkReports("afterReset");
    checkCounters("afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
